exec_ctrl_unit: RTL
===================

EXEC_CTRL_UNIT -- requirements
Module: exec_ctrl_unit

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand/result width (even, >=8).
REQ-002 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have ports: rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: alu_op  in  4  0000 R, 0001 I, 0010 branch, 0011 load, 0100 store, 0101 JALR, 0110 JAL, 0111 AUIPC, 1000 LUI; others reserved.
REQ-005 SHALL have ports: funct3  in  3 | inst30  in  1 | inst25  in  1  instruction fields (inst25 = funct7[0]).
REQ-006 SHALL have ports: valid_in  in  1  EX stage holds a valid instruction.
REQ-007 SHALL have ports: flush  in  1  abort any in-flight mul/div.
REQ-008 SHALL have ports: op_a, op_b  in  XLEN  rs1/rs2 operands.
REQ-009 SHALL have ports: alu_sel  out  4  ALU_* code from defines.v.
REQ-010 SHALL have ports: md_sel  out  1  EX result is md_result (M-op decoded).
REQ-011 SHALL have ports: md_result  out  XLEN | md_done  out  1 | stall  out  1 | illegal  out  1.

Function
REQ-012 alu_sel SHALL be combinational: op 0000 without inst25 maps funct3 to OR/AND/XOR/SLT/SLTU/SLL, ADD/SUB and SRL/SRA by inst30; 0001 same but funct3 000 always ADD; 0010 SUB; 0011/0100/0101/0110 ADD; 0111 AUIPC; 1000 LUI; reserved op -> ADD with illegal=1 when valid_in.
REQ-013 M-op SHALL be alu_op==0000 & inst25; funct3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU; md_sel=1, alu_sel=ADD.
REQ-014 FSM states IDLE, MUL, DIV, DONE; IDLE with valid_in & M-op SHALL latch operands/funct3 and go MUL or DIV.
REQ-015 stall SHALL equal valid_in & M-op & (state != DONE), combinational, so the request cycle itself stalls.
REQ-016 MUL: shift-add on magnitudes, XLEN iterations via down-counter, 2*XLEN product, sign fixed by final negation per funct3 signedness; then DONE.
REQ-017 DIV: restoring, XLEN iterations, magnitudes with quotient sign = sign(a) xor sign(b), remainder sign = sign(a); then DONE.
REQ-018 Divide-by-zero SHALL go IDLE->DONE directly: quotient all-ones, remainder = op_a.
REQ-019 Signed overflow (a = -2^(XLEN-1), b = -1) SHALL go IDLE->DONE directly: quotient = op_a, remainder 0.
REQ-020 Latency: request at cycle T, DONE at T+XLEN+1 for iterative ops, T+1 for REQ-018/019.
REQ-021 DONE SHALL last one cycle: md_done=1, stall=0, md_result updated on entry, next state IDLE.
REQ-022 md_result SHALL hold its value until the next DONE entry; md_done=0 outside DONE.
REQ-023 MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits.
REQ-024 flush in any state SHALL force IDLE next edge, md_done=0, md_result unchanged; flush has priority over a new request.
REQ-025 valid_in deasserting mid-operation SHALL NOT abort; only flush or reset abort.

Reset
REQ-026 rst low SHALL immediately force state IDLE, counter 0, operand/partial registers 0, md_result 0, md_done 0; stall then depends only on inputs.

Configuration
REQ-027 Macro EXEC_DIV_EN defined: DIV/DIVU/REM/REMU supported per REQ-017..019.
REQ-028 EXEC_DIV_EN undefined: divider logic absent; funct3 1xx M-op SHALL give illegal=1 (when valid_in), stall=0, md_sel=1, md_result unchanged, no state change.

Verification
REQ-029 MUL 7 x -3 (XLEN=32) -> md_result 0xFFFFFFEB, md_done at T+33, stall high T..T+32.
REQ-030 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU -1 x 2 -> 0xFFFFFFFF.
REQ-031 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at T+1; DIVU 5/0 -> 0xFFFFFFFF; REM 7/0 -> 7; REM -7/2 -> 0xFFFFFFFF.
REQ-032 flush at iteration 10 of DIVU -> IDLE next edge, md_done stays 0, md_result keeps prior value; rst low mid-MUL -> all outputs reset asynchronously.
REQ-033 alu_op 0000, funct3 000, inst30=1, inst25=0 -> alu_sel ALU_SUB, stall 0; alu_op 1111 valid -> illegal 1, alu_sel ALU_ADD.
REQ-034 Build without EXEC_DIV_EN: DIV request -> illegal 1, stall 0, no md_done.

Source files
------------

// File: rtl/exec_ctrl_unit.sv
// EX-stage control: ALU select decode plus an iterative shift-add multiplier / restoring divider.
// Build with EXEC_DIV_EN defined to include DIV/DIVU/REM/REMU; otherwise those M-ops decode as illegal.
module exec_ctrl_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            inst30,
  input  logic            inst25,
  input  logic            valid_in,
  input  logic            flush,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [3:0]      alu_sel,
  output logic            md_sel,
  output logic [XLEN-1:0] md_result,
  output logic            md_done,
  output logic            stall,
  output logic            illegal
);
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                         ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_AUIPC = 4'd10, ALU_LUI = 4'd11;
  localparam logic [1:0] S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3;
  localparam int CW = $clog2(XLEN + 1);

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   opa_q, opa_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              neg_q, neg_d, hi_q, hi_d;
  logic [XLEN-1:0]   res_q, res_d;

  logic m_op, m_ok, rsvd;
  logic a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod_nxt, mul_fin;

  assign m_op = (alu_op == 4'b0000) && inst25;
`ifdef EXEC_DIV_EN
  assign m_ok = m_op;
`else
  assign m_ok = m_op && !funct3[2];
`endif

  always_comb begin
    alu_sel = ALU_ADD;
    rsvd    = 1'b0;
    case (alu_op)
      4'b0000, 4'b0001: begin
        case (funct3)
          3'b000:  alu_sel = (alu_op == 4'b0000 && inst30) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_sel = ALU_SLL;
          3'b010:  alu_sel = ALU_SLT;
          3'b011:  alu_sel = ALU_SLTU;
          3'b100:  alu_sel = ALU_XOR;
          3'b101:  alu_sel = inst30 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_sel = ALU_OR;
          default: alu_sel = ALU_AND;
        endcase
        if (m_op) alu_sel = ALU_ADD;
      end
      4'b0010: alu_sel = ALU_SUB;
      4'b0011, 4'b0100, 4'b0101, 4'b0110: alu_sel = ALU_ADD;
      4'b0111: alu_sel = ALU_AUIPC;
      4'b1000: alu_sel = ALU_LUI;
      default: rsvd = 1'b1;
    endcase
  end

  assign md_sel  = m_op;
  assign illegal = valid_in && (rsvd || (m_op && !m_ok));
  assign stall   = valid_in && m_ok && (state_q != S_DONE);
  assign md_done = (state_q == S_DONE) && !flush;
  assign md_result = res_q;

  // Mul: MULHU unsigned, MULHSU only rs1 signed; div: the U variants are unsigned.
  assign a_signed = funct3[2] ? !funct3[0] : (funct3[1:0] != 2'b11);
  assign b_signed = funct3[2] ? !funct3[0] : !funct3[1];
  assign a_neg    = a_signed && op_a[XLEN-1];
  assign b_neg    = b_signed && op_b[XLEN-1];
  assign a_mag    = a_neg ? -op_a : op_a;
  assign b_mag    = b_neg ? -op_b : op_b;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opa_q} : '0);
  assign prod_nxt = {mul_sum, acc_q[XLEN-1:1]};
  assign mul_fin  = neg_q ? -prod_nxt : prod_nxt;

`ifdef EXEC_DIV_EN
  logic [XLEN:0]     r_sh, diff;
  logic              ge, div_ovf;
  logic [2*XLEN-1:0] div_nxt;
  logic [XLEN-1:0]   div_sel;
  assign r_sh    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign diff    = r_sh - {1'b0, opa_q};
  assign ge      = !diff[XLEN];
  assign div_nxt = {(ge ? diff[XLEN-1:0] : r_sh[XLEN-1:0]), acc_q[XLEN-2:0], ge};
  assign div_sel = hi_q ? div_nxt[2*XLEN-1:XLEN] : div_nxt[XLEN-1:0];
  assign div_ovf = !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    res_d   = res_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid_in && m_ok) begin
            if (!funct3[2]) begin
              acc_d   = {{XLEN{1'b0}}, b_mag};
              opa_d   = a_mag;
              neg_d   = a_neg ^ b_neg;
              hi_d    = (funct3[1:0] != 2'b00);
              cnt_d   = CW'(XLEN);
              state_d = S_MUL;
            end
`ifdef EXEC_DIV_EN
            else if (op_b == '0) begin
              res_d   = funct3[1] ? op_a : '1;
              state_d = S_DONE;
            end else if (div_ovf) begin
              res_d   = funct3[1] ? '0 : op_a;
              state_d = S_DONE;
            end else begin
              acc_d   = {{XLEN{1'b0}}, a_mag};
              opa_d   = b_mag;
              neg_d   = funct3[1] ? a_neg : (a_neg ^ b_neg);
              hi_d    = funct3[1];
              cnt_d   = CW'(XLEN);
              state_d = S_DIV;
            end
`endif
          end
        end
        S_MUL: begin
          acc_d = prod_nxt;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            res_d   = hi_q ? mul_fin[2*XLEN-1:XLEN] : mul_fin[XLEN-1:0];
            state_d = S_DONE;
          end
        end
        S_DIV: begin
`ifdef EXEC_DIV_EN
          acc_d = div_nxt;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            res_d   = neg_q ? -div_sel : div_sel;
            state_d = S_DONE;
          end
`else
          state_d = S_IDLE;
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      hi_q    <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      res_q   <= res_d;
    end
  end
endmodule
